// File: rtl/sar_adc_scan_if.sv
// Request and result bus between the multi-channel SAR controller and its neighbours.
// Result side: dout_valid stays high until an edge sees dout_ready; a new result may overwrite an untaken one.
interface sar_adc_scan_if #(
  parameter int WIDTH  = 12,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic                    start;
  logic                    mode;
  logic [CH_W-1:0]         ch_sel;
  logic [NUM_CH*WIDTH-1:0] vin_bus;
  logic                    busy;
  logic [WIDTH-1:0]        dout;
  logic [CH_W-1:0]         dout_ch;
  logic                    dout_valid;
  logic                    dout_ready;
  logic                    overrun;
  logic                    seq_done;

  modport master (
    output start, mode, ch_sel, vin_bus, dout_ready,
    input  busy, dout, dout_ch, dout_valid, overrun, seq_done
  );

  modport slave (
    input  start, mode, ch_sel, vin_bus, dout_ready,
    output busy, dout, dout_ch, dout_valid, overrun, seq_done
  );
endinterface

// File: rtl/sar_adc_scan.sv
// Multi-channel successive-approximation controller: single-channel or ascending scan,
// one tagged result per channel on a non-stalling valid/ready output with overrun flag.
module sar_adc_scan #(
  parameter int WIDTH         = 12,
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 2,
  parameter int SAMPLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sar_adc_scan_if.slave        bus,
  output logic [1:0]           state_o
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sar_q, sar_d;
  logic [WIDTH-1:0]   held_q, held_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [CH_W-1:0]    dout_ch_q, dout_ch_d;
  logic               dout_valid_q, dout_valid_d;
  logic               overrun_q, overrun_d;
  logic               seq_done_q, seq_done_d;

  logic [WIDTH-1:0]   one_hot;
  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   sar_next;
  logic               ch_sel_ok;
  logic               last_ch;
  logic               result_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      ch_q         <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      sar_q        <= '0;
      held_q       <= '0;
      busy_q       <= 1'b0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sar_q        <= sar_d;
      held_q       <= held_d;
      busy_q       <= busy_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      seq_done_q   <= seq_done_d;
    end
  end

  // One trial bit per CONVERT edge, MSB first; sar_next already folds in the current decision.
  assign one_hot   = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
  assign trial     = sar_q | one_hot;
  assign sar_next  = (held_q >= trial) ? trial : sar_q;
  assign ch_sel_ok = ({1'b0, bus.ch_sel} < (CH_W+1)'(NUM_CH));
  assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    ch_d         = ch_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sar_d        = sar_q;
    held_d       = held_q;
    busy_d       = busy_q;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    seq_done_d   = 1'b0;
    result_load  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.mode || ch_sel_ok)) begin
          mode_d  = bus.mode;
          ch_d    = bus.mode ? '0 : bus.ch_sel;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          held_d  = bus.vin_bus[ch_q*WIDTH +: WIDTH];
          sar_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          state_d = S_CONVERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CONVERT: begin
        sar_d = sar_next;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          result_load = 1'b1;
          dout_d      = sar_next;
          dout_ch_d   = ch_q;
          if (mode_q && !last_ch) begin
            ch_d    = ch_q + 1'b1;
            cnt_d   = '0;
            state_d = S_SAMPLE;
          end else begin
            busy_d     = 1'b0;
            seq_done_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A landing result wins over acceptance; it only counts as overrun if nobody took the old one.
    if (result_load) begin
      dout_valid_d = 1'b1;
      overrun_d    = dout_valid_q && !bus.dout_ready;
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_ch    = dout_ch_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.seq_done   = seq_done_q;
  assign state_o        = state_q;

endmodule
